// File: rtl/ram_ctrl.sv
// Parametrised single-port RAM with request/acknowledge controller, clear sweep,
// registered read path and auto-increment pointer. Optional parity: `define RAM_PARITY_EN.
module ram_ctrl #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              use_ptr,
  input  logic              ptr_load,
  input  logic              clr,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] ptr,
  output logic              busy,
  output logic              parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACK} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_dout;
  logic              r_ack;
  logic              r_busy;
  logic [MEM_W-1:0]  r_mem [DEPTH];

  logic              w_ready;
  logic              w_accept;
  logic              w_clearing;
  logic [ADDR_W-1:0] w_ea;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_wdata_raw;
  logic [MEM_W-1:0]  w_mem_wdata;
  logic [MEM_W-1:0]  w_rd_word;

  assign w_ready     = (r_state == S_IDLE) && !clr;
  assign w_accept    = w_ready && req;
  assign w_clearing  = (r_state == S_CLEAR);
  assign w_ea        = use_ptr ? r_ptr : addr;
  assign w_mem_we    = reset_n && (w_clearing || (w_accept && we));
  assign w_mem_addr  = w_clearing ? r_idx : w_ea;
  assign w_wdata_raw = w_clearing ? CLEAR_VAL : din;
  assign w_rd_word   = r_mem[w_ea];

`ifdef RAM_PARITY_EN
  logic r_perr;
  // Stored parity bit makes the XOR of the whole word zero when intact.
  assign w_mem_wdata = {^w_wdata_raw, w_wdata_raw};
  assign parity_err  = r_perr;
`else
  assign w_mem_wdata = w_wdata_raw;
  assign parity_err  = 1'b0;
`endif

  // Single write port shared by the clear sweep and accepted writes.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
      r_busy  <= 1'b1;
      r_ack   <= 1'b0;
      r_dout  <= '0;
      r_ptr   <= '0;
`ifdef RAM_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_idx <= r_idx + ADDR_W'(1);
          if (r_idx == {ADDR_W{1'b1}}) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (clr) begin
            r_idx   <= '0;
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
          end else if (req) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            if (!we) begin
              r_dout <= w_rd_word[DATA_W-1:0];
`ifdef RAM_PARITY_EN
              r_perr <= ^w_rd_word;
`endif
            end
          end
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // A load takes priority; the coinciding access already used the old pointer.
      if (ptr_load) begin
        r_ptr <= addr;
      end else if (w_accept && use_ptr) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end
    end
  end

  assign ready = w_ready;
  assign ack   = r_ack;
  assign dout  = r_dout;
  assign ptr   = r_ptr;
  assign busy  = r_busy;

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl (default parameters) against an array/pointer model.
// Parity scenario compiles only with RAM_PARITY_EN defined.
module tb_ram_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, we, use_ptr, ptr_load, clr;
  logic [7:0]  addr;
  logic [15:0] din;
  logic        ready, ack, busy, parity_err;
  logic [15:0] dout;
  logic [7:0]  ptr;

  int checks = 0;
  int errors = 0;

  logic [15:0] mmem [256];
  logic [7:0]  mptr;
  logic [15:0] mdout;

  ram_ctrl #(.DATA_W(16), .ADDR_W(8), .CLEAR_VAL(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .din(din),
    .use_ptr(use_ptr), .ptr_load(ptr_load), .clr(clr), .ready(ready), .ack(ack),
    .dout(dout), .ptr(ptr), .busy(busy), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mmem[i] = 16'h0000;
  endtask

  // Reference behaviour of one accepted access.
  task automatic model_access(input logic w, input logic [7:0] a, input logic [15:0] d,
                              input logic up, input logic pl);
    logic [7:0] ea;
    ea = up ? mptr : a;
    if (w) mmem[ea] = d;
    else   mdout = mmem[ea];
    if (pl)      mptr = a;
    else if (up) mptr = mptr + 8'd1;
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [15:0] d,
                        input logic up, input logic pl,
                        output logic rdy0, output logic ack1, output logic rdy1,
                        output logic [15:0] dout1, output logic ack2);
    req = 1'b1; we = w; addr = a; din = d; use_ptr = up; ptr_load = pl;
    #1 rdy0 = ready;
    tick();
    req = 1'b0; we = 1'b0; use_ptr = 1'b0; ptr_load = 1'b0;
    ack1 = ack; rdy1 = ready; dout1 = dout;
    tick();
    ack2 = ack;
    model_access(w, a, d, up, pl);
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0; req = 0; we = 0; addr = 0; din = 0; use_ptr = 0; ptr_load = 0; clr = 0;
    mptr = 8'd0; mdout = 16'h0000;
    repeat (3) tick();
    checks++; if ({busy, ready, ack} !== 3'b100) begin errors++; $display("[TB] FAIL reset_ctrl: busy/ready/ack=%b expected 100", {busy, ready, ack}); end
    checks++; if ({dout, ptr, parity_err} !== 25'd0) begin errors++; $display("[TB] FAIL reset_data: dout=%h ptr=%h perr=%b expected zeros", dout, ptr, parity_err); end
    reset_n = 1'b1;
    wait_sweep(n);
    model_clear();
    checks++; if (n != 256) begin errors++; $display("[TB] FAIL sweep_len: busy cycles=%0d expected 256", n); end
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_sweep: got %b expected 1", ready); end
  endtask

  task automatic test_clear_contents();
    logic r0, a1, r1, a2;
    logic [15:0] d1;
    logic [7:0] list [3];
    list[0] = 8'h00; list[1] = 8'h7F; list[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      access(1'b0, list[i], 16'h0, 1'b0, 1'b0, r0, a1, r1, d1, a2);
      checks++; if (d1 !== mdout || a1 !== 1'b1) begin errors++; $display("[TB] FAIL clear_read[%h]: dout=%h ack=%b expected %h ack 1", list[i], d1, a1, mdout); end
    end
  endtask

  task automatic test_write_read();
    logic r0, a1, r1, a2;
    logic [15:0] d1;
    access(1'b1, 8'h12, 16'hBEEF, 1'b0, 1'b0, r0, a1, r1, d1, a2);
    checks++; if ({r0, a1, r1, a2} !== 4'b1100) begin errors++; $display("[TB] FAIL write_handshake: rdy/ack/rdy/ack=%b expected 1100", {r0, a1, r1, a2}); end
    access(1'b0, 8'h12, 16'h0, 1'b0, 1'b0, r0, a1, r1, d1, a2);
    checks++; if ({r0, a1, r1, a2} !== 4'b1100) begin errors++; $display("[TB] FAIL read_handshake: rdy/ack/rdy/ack=%b expected 1100", {r0, a1, r1, a2}); end
    checks++; if (d1 !== 16'hBEEF) begin errors++; $display("[TB] FAIL read_beef: dout=%h expected beef", d1); end
    checks++; if (dout !== 16'hBEEF) begin errors++; $display("[TB] FAIL dout_hold: dout=%h expected beef", dout); end
  endtask

  task automatic test_pointer_wrap();
    logic r0, a1, r1, a2;
    logic [15:0] d1;
    addr = 8'hFE; ptr_load = 1'b1;
    tick();
    ptr_load = 1'b0;
    mptr = 8'hFE;
    checks++; if (ptr !== 8'hFE) begin errors++; $display("[TB] FAIL ptr_load: ptr=%h expected fe", ptr); end
    access(1'b1, 8'h00, 16'h1111, 1'b1, 1'b0, r0, a1, r1, d1, a2);
    access(1'b1, 8'h00, 16'h2222, 1'b1, 1'b0, r0, a1, r1, d1, a2);
    checks++; if (ptr !== 8'h00) begin errors++; $display("[TB] FAIL ptr_wrap: ptr=%h expected 00", ptr); end
    access(1'b0, 8'hFE, 16'h0, 1'b0, 1'b0, r0, a1, r1, d1, a2);
    checks++; if (d1 !== 16'h1111) begin errors++; $display("[TB] FAIL ptr_write_fe: dout=%h expected 1111", d1); end
    access(1'b0, 8'hFF, 16'h0, 1'b0, 1'b0, r0, a1, r1, d1, a2);
    checks++; if (d1 !== 16'h2222) begin errors++; $display("[TB] FAIL ptr_write_ff: dout=%h expected 2222", d1); end
    access(1'b0, 8'h55, 16'h0, 1'b1, 1'b0, r0, a1, r1, d1, a2);
    checks++; if (d1 !== mdout || ptr !== 8'h01) begin errors++; $display("[TB] FAIL ptr_read_00: dout=%h ptr=%h expected %h ptr 01", d1, ptr, mdout); end
  endtask

  task automatic test_random();
    logic r0, a1, r1, a2, w, up, pl;
    logic [15:0] d1, d;
    logic [7:0] a;
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      up = 1'($urandom_range(0, 1));
      pl = ($urandom_range(0, 5) == 0);
      a  = 8'($urandom_range(0, 15));
      d  = 16'($urandom);
      access(w, a, d, up, pl, r0, a1, r1, d1, a2);
      checks++;
      if ({r0, a1, r1, a2} !== 4'b1100 || dout !== mdout || ptr !== mptr || parity_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL random[%0d]: hs=%b dout=%h ptr=%h perr=%b expected hs=1100 dout=%h ptr=%h perr=0",
                 i, {r0, a1, r1, a2}, dout, ptr, parity_err, mdout, mptr);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    req = 1'b1; we = 1'b0; use_ptr = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_ack = (k % 2) == 1;
      if (exp_ack) begin
        mdout = mmem[mptr];
        mptr  = mptr + 8'd1;
      end
      checks++;
      if (ack !== exp_ack || ready !== !exp_ack || dout !== mdout || ptr !== mptr) begin
        errors++;
        $display("[TB] FAIL b2b[%0d]: ack=%b ready=%b dout=%h ptr=%h expected ack=%b ready=%b dout=%h ptr=%h",
                 k, ack, ready, dout, ptr, exp_ack, !exp_ack, mdout, mptr);
      end
    end
    req = 1'b0; use_ptr = 1'b0;
  endtask

  task automatic test_clr_ignored();
    req = 1'b1; we = 1'b0; addr = 8'h12;
    tick();
    req = 1'b0; clr = 1'b1;
    mdout = mmem[8'h12];
    tick();
    clr = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || ready !== 1'b1) begin errors++; $display("[TB] FAIL clr_in_ack: busy=%b ready=%b expected 0 1", busy, ready); end
  endtask

  task automatic test_clr_collision();
    logic r0, a1, r1, a2;
    logic [15:0] d1;
    logic [7:0] a;
    int n;
    for (int i = 0; i < 4; i++) access(1'b1, 8'(i * 37 + 5), 16'($urandom) | 16'h0100, 1'b0, 1'b0, r0, a1, r1, d1, a2);
    req = 1'b1; we = 1'b0; addr = 8'h05; clr = 1'b1;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL clr_ready: ready=%b expected 0", ready); end
    tick();
    req = 1'b0; clr = 1'b0;
    checks++; if (ack !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL clr_collide: ack=%b busy=%b expected 0 1", ack, busy); end
    wait_sweep(n);
    model_clear();
    checks++; if (n != 256) begin errors++; $display("[TB] FAIL clr_sweep_len: busy cycles=%0d expected 256", n); end
    for (int i = 0; i < 4; i++) begin
      a = 8'(i * 37 + 5);
      access(1'b0, a, 16'h0, 1'b0, 1'b0, r0, a1, r1, d1, a2);
      checks++; if (d1 !== mmem[a]) begin errors++; $display("[TB] FAIL clr_contents[%h]: dout=%h expected %h", a, d1, mmem[a]); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic r0, a1, r1, a2;
    logic [15:0] d1;
    int n;
    access(1'b1, 8'h03, 16'hA5A5, 1'b0, 1'b0, r0, a1, r1, d1, a2);
    access(1'b0, 8'h03, 16'h0, 1'b0, 1'b1, r0, a1, r1, d1, a2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    mptr = 8'd0; mdout = 16'h0000;
    checks++; if (dout !== 16'h0000 || ptr !== 8'h00) begin errors++; $display("[TB] FAIL reset_clears: dout=%h ptr=%h expected 0000 00", dout, ptr); end
    repeat (100) tick();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, ready, ack, parity_err} !== 4'b1000 || dout !== 16'h0 || ptr !== 8'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset: busy/ready/ack/perr=%b dout=%h ptr=%h expected 1000 0000 00", {busy, ready, ack, parity_err}, dout, ptr);
    end
    reset_n = 1'b1;
    wait_sweep(n);
    model_clear();
    checks++; if (n != 256) begin errors++; $display("[TB] FAIL mid_sweep_len: busy cycles=%0d expected 256", n); end
    access(1'b0, 8'h03, 16'h0, 1'b0, 1'b0, r0, a1, r1, d1, a2);
    checks++; if (d1 !== mdout) begin errors++; $display("[TB] FAIL mid_contents: dout=%h expected %h", d1, mdout); end
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity();
    logic r0, a1, r1, a2;
    logic [15:0] d1;
    access(1'b1, 8'h05, 16'h0001, 1'b0, 1'b0, r0, a1, r1, d1, a2);
    dut.r_mem[5][0] = ~dut.r_mem[5][0];
    access(1'b0, 8'h05, 16'h0, 1'b0, 1'b0, r0, a1, r1, d1, a2);
    checks++; if (parity_err !== 1'b1) begin errors++; $display("[TB] FAIL parity_flip: perr=%b expected 1", parity_err); end
    access(1'b1, 8'h06, 16'h0003, 1'b0, 1'b0, r0, a1, r1, d1, a2);
    access(1'b0, 8'h06, 16'h0, 1'b0, 1'b0, r0, a1, r1, d1, a2);
    checks++; if (parity_err !== 1'b0 || d1 !== 16'h0003) begin errors++; $display("[TB] FAIL parity_clean: perr=%b dout=%h expected 0 0003", parity_err, d1); end
  endtask
`endif

  initial begin
    test_reset();
    test_clear_contents();
    test_write_read();
    test_pointer_wrap();
    test_random();
    test_back_to_back();
    test_clr_ignored();
    test_clr_collision();
    test_reset_mid_sweep();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
